data_sequencer: RTL

Upstream command sequencer for the 4-cell `data_selector` stage. It accepts one command at a time over a valid/ready handshake and converts it into correctly timed `read_sig`/`write_sig`/`adr`/`data` strobes for the selector. For reads, it captures the selector's registered `data_o` at the one cycle it is valid and returns it on a valid/ready response channel. It never drives the selector's illegal `{read,write}=11` code.

---
 rtl/data_seq_pkg.sv | 20 ++
 rtl/data_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/data_seq_pkg.sv
// rtl/data_seq_pkg.sv - shared types and constants for the data_selector command sequencer
package data_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [7:0] ERR_DATA = 8'hFF;

endpackage

// File: rtl/data_sequencer.sv
// rtl/data_sequencer.sv - one-at-a-time command sequencer driving the 4-cell data_selector
module data_sequencer
    import data_seq_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [1:0]  cmd_adr_i,
    input  logic [7:0]  cmd_data_i,
    output logic        sel_read_o,
    output logic        sel_write_o,
    output logic [1:0]  sel_adr_o,
    output logic [7:0]  sel_data_o,
    input  logic [7:0]  sel_rdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_err_o,
    output logic [15:0] txn_cnt_o
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_RESP  = ST_RESP;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [1:0]    state;
    logic          is_read;
    logic [CW-1:0] wait_cnt;
    logic [15:0]   txn_cnt_q;
    logic          wait_last;

    assign wait_last   = (wait_cnt == CW'(RD_LAT - 1));
    assign cmd_ready_o = (state == S_IDLE);
    assign rsp_valid_o = (state == S_RESP);
    assign txn_cnt_o   = txn_cnt_q;

    // The selector's naming is swapped: {read_sig,write_sig}=01 reads, 10 writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            is_read     <= 1'b0;
            wait_cnt    <= '0;
            txn_cnt_q   <= '0;
            sel_read_o  <= 1'b0;
            sel_write_o <= 1'b0;
            sel_adr_o   <= '0;
            sel_data_o  <= '0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        case (cmd_op_i)
                            OP_READ: begin
                                sel_read_o  <= 1'b0;
                                sel_write_o <= 1'b1;
                                sel_adr_o   <= cmd_adr_i;
                                sel_data_o  <= cmd_data_i;
                                is_read     <= 1'b1;
                                state       <= S_ISSUE;
                            end
                            OP_WRITE: begin
                                sel_read_o  <= 1'b1;
                                sel_write_o <= 1'b0;
                                sel_adr_o   <= cmd_adr_i;
                                sel_data_o  <= cmd_data_i;
                                is_read     <= 1'b0;
                                state       <= S_ISSUE;
                            end
                            OP_ILLEGAL: begin
                                rsp_err_o  <= 1'b1;
                                rsp_data_o <= ERR_DATA;
                                state      <= S_RESP;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ISSUE: begin
                    sel_read_o  <= 1'b0;
                    sel_write_o <= 1'b0;
                    txn_cnt_q   <= txn_cnt_q + 16'd1;
                    if (is_read) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end else begin
                        rsp_data_o <= sel_data_o;
                        rsp_err_o  <= 1'b0;
                        state      <= S_RESP;
                    end
                end
                // The selector holds data_o for one cycle only; later it reads back 0.
                S_WAIT: begin
                    if (wait_last) begin
                        rsp_data_o <= sel_rdata_i;
                        rsp_err_o  <= 1'b0;
                        state      <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
